// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared encodings for the multi-cycle RV32 core
package riscv_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [31:0] ECALL_WORD = 32'h0000_0073;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;
  localparam logic [2:0] F3_W    = 3'b010;
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [2:0] {
    ST_IDLE, ST_FETCH, ST_DECODE, ST_EXEC, ST_MEM, ST_WB, ST_HALT
  } state_t;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
    ALU_SLT, ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA
  } alu_op_t;

endpackage

// File: rtl/riscv_alu.sv
// rtl/riscv_alu.sv - combinational ALU; zero flag drives the branch decision
module riscv_alu
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  alu_op_t         op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] y,
  output logic            zero
);

  localparam int SHW = $clog2(XLEN);

  logic [SHW-1:0] shamt;
  assign shamt = b[SHW-1:0];

  always_comb begin
    y = '0;
    case (op)
      ALU_ADD:  y = a + b;
      ALU_SUB:  y = a - b;
      ALU_AND:  y = a & b;
      ALU_OR:   y = a | b;
      ALU_XOR:  y = a ^ b;
      ALU_SLT:  y = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_SLTU: y = {{(XLEN-1){1'b0}}, (a < b)};
      ALU_SLL:  y = a << shamt;
      ALU_SRL:  y = a >> shamt;
      ALU_SRA:  y = $unsigned($signed(a) >>> shamt);
      default:  y = '0;
    endcase
  end

  assign zero = (y == '0);

endmodule

// File: rtl/riscv_mc_core.sv
// rtl/riscv_mc_core.sv - multi-cycle RV32 subset core with program-loadable imem
module riscv_mc_core
  import riscv_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int IMEM_DEPTH = 64,
  parameter int DMEM_DEPTH = 64
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          prog_we,
  input  logic [$clog2(IMEM_DEPTH)-1:0] prog_addr,
  input  logic [31:0]                   prog_data,
  input  logic                          run,
  output logic                          busy,
  output logic                          halted,
  output logic                          illegal,
  output logic [XLEN-1:0]               pc_o,
  input  logic [4:0]                    dbg_raddr,
  output logic [XLEN-1:0]               dbg_rdata
);

  localparam int IW = $clog2(IMEM_DEPTH);
  localparam int DW = $clog2(DMEM_DEPTH);

  state_t state, state_nx;
  logic [XLEN-1:0] pc, pc_plus4, rs1_q, rs2_q, imm_q, res_q, alu_b, alu_y, imm_d;
  logic [XLEN-1:0] imm_i, imm_s, imm_b;
  logic [31:0] ir;
  logic illegal_q, alu_zero, branch_taken, idle_like;
  logic legal, is_ecall, is_load, is_store, is_branch, writes_rd, use_rs2;
  alu_op_t alu_op;
  logic [6:0] opcode, funct7;
  logic [2:0] funct3;
  logic [4:0] rd, rs1, rs2;

  logic [XLEN-1:0] regs [32];
  logic [31:0]     imem [IMEM_DEPTH];
  logic [XLEN-1:0] dmem [DMEM_DEPTH];

  assign opcode = ir[6:0];
  assign rd     = ir[11:7];
  assign funct3 = ir[14:12];
  assign rs1    = ir[19:15];
  assign rs2    = ir[24:20];
  assign funct7 = ir[31:25];
  assign imm_i  = {{(XLEN-12){ir[31]}}, ir[31:20]};
  assign imm_s  = {{(XLEN-12){ir[31]}}, ir[31:25], ir[11:7]};
  assign imm_b  = {{(XLEN-12){ir[31]}}, ir[7], ir[30:25], ir[11:8], 1'b0};

  // Decode is purely a function of IR, which stays stable for the whole instruction.
  always_comb begin
    legal = 1'b0; is_ecall = 1'b0; is_load = 1'b0; is_store = 1'b0;
    is_branch = 1'b0; writes_rd = 1'b0; use_rs2 = 1'b0;
    alu_op = ALU_ADD; imm_d = imm_i;
    if (ir == ECALL_WORD) begin
      is_ecall = 1'b1;
    end else begin
      case (opcode)
        OP_R: begin
          use_rs2 = 1'b1; writes_rd = 1'b1;
          if (funct7 == F7_BASE) begin
            legal = 1'b1;
            case (funct3)
              F3_ADD:  alu_op = ALU_ADD;
              F3_SLL:  alu_op = ALU_SLL;
              F3_SLT:  alu_op = ALU_SLT;
              F3_SLTU: alu_op = ALU_SLTU;
              F3_XOR:  alu_op = ALU_XOR;
              F3_SR:   alu_op = ALU_SRL;
              F3_OR:   alu_op = ALU_OR;
              F3_AND:  alu_op = ALU_AND;
              default: alu_op = ALU_ADD;
            endcase
          end else if (funct7 == F7_ALT && funct3 == F3_ADD) begin
            legal = 1'b1; alu_op = ALU_SUB;
          end else if (funct7 == F7_ALT && funct3 == F3_SR) begin
            legal = 1'b1; alu_op = ALU_SRA;
          end
        end
        OP_I: begin
          writes_rd = 1'b1; legal = 1'b1;
          case (funct3)
            F3_ADD:  alu_op = ALU_ADD;
            F3_SLT:  alu_op = ALU_SLT;
            F3_XOR:  alu_op = ALU_XOR;
            F3_OR:   alu_op = ALU_OR;
            F3_AND:  alu_op = ALU_AND;
            default: legal = 1'b0;
          endcase
        end
        OP_LOAD: begin
          writes_rd = 1'b1; is_load = 1'b1; legal = (funct3 == F3_W);
        end
        OP_STORE: begin
          is_store = 1'b1; imm_d = imm_s; legal = (funct3 == F3_W);
        end
        OP_BRANCH: begin
          is_branch = 1'b1; use_rs2 = 1'b1; alu_op = ALU_SUB; imm_d = imm_b;
          legal = (funct3 == F3_BEQ) || (funct3 == F3_BNE);
        end
        default: legal = 1'b0;
      endcase
    end
  end

  assign alu_b = use_rs2 ? rs2_q : imm_q;

  riscv_alu #(.XLEN(XLEN)) u_alu (
    .op   (alu_op),
    .a    (rs1_q),
    .b    (alu_b),
    .y    (alu_y),
    .zero (alu_zero)
  );

  assign branch_taken = (funct3 == F3_BEQ) ? alu_zero : ~alu_zero;
  assign pc_plus4     = pc + XLEN'(4);
  assign idle_like    = (state == ST_IDLE) || (state == ST_HALT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE, ST_HALT: if (run) state_nx = ST_FETCH;
      ST_FETCH:  state_nx = ST_DECODE;
      ST_DECODE: state_nx = (is_ecall || !legal) ? ST_HALT : ST_EXEC;
      ST_EXEC:   state_nx = is_branch ? ST_FETCH : ((is_load || is_store) ? ST_MEM : ST_WB);
      ST_MEM:    state_nx = is_load ? ST_WB : ST_FETCH;
      ST_WB:     state_nx = ST_FETCH;
      default:   state_nx = ST_IDLE;
    endcase
  end

  // PC only moves in the final state of an instruction; HALT paths leave it untouched.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc        <= '0;
      ir        <= '0;
      illegal_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_HALT: if (run) begin
          pc        <= '0;
          illegal_q <= 1'b0;
        end
        ST_FETCH:  ir <= imem[pc[IW+1:2]];
        ST_DECODE: if (!is_ecall && !legal) illegal_q <= 1'b1;
        ST_EXEC:   if (is_branch) pc <= branch_taken ? pc + imm_q : pc_plus4;
        ST_MEM:    if (is_store) pc <= pc_plus4;
        ST_WB:     pc <= pc_plus4;
        default:   ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (prog_we && idle_like) imem[prog_addr] <= prog_data;
  end

  always_ff @(posedge clk) begin
    case (state)
      ST_DECODE: begin
        rs1_q <= (rs1 == 5'd0) ? '0 : regs[rs1];
        rs2_q <= (rs2 == 5'd0) ? '0 : regs[rs2];
        imm_q <= imm_d;
      end
      ST_EXEC: res_q <= alu_y;
      ST_MEM: begin
        if (is_load)  res_q <= dmem[res_q[DW+1:2]];
        if (is_store) dmem[res_q[DW+1:2]] <= rs2_q;
      end
      ST_WB: if (writes_rd && rd != 5'd0) regs[rd] <= res_q;
      default: ;
    endcase
  end

  assign busy      = !idle_like;
  assign halted    = (state == ST_HALT);
  assign illegal   = illegal_q;
  assign pc_o      = pc;
  assign dbg_rdata = (dbg_raddr == 5'd0) ? '0 : regs[dbg_raddr];

endmodule

// File: tb/tb_riscv_mc_core.sv
// tb/tb_riscv_mc_core.sv - directed and random programs against an instruction-level model
module tb_riscv_mc_core;

  localparam int IMEM = 64;
  localparam int DMEM = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        prog_we = 1'b0;
  logic [5:0]  prog_addr = '0;
  logic [31:0] prog_data = '0;
  logic        run = 1'b0;
  logic        busy, halted, illegal;
  logic [31:0] pc_o, dbg_rdata;
  logic [4:0]  dbg_raddr = '0;

  int n_vec = 0;
  int n_miss = 0;

  logic [31:0] m_x [32];
  logic [31:0] m_imem [IMEM];
  logic [31:0] m_dmem [DMEM];
  logic [31:0] m_pc;
  logic        m_ill;

  riscv_mc_core #(.XLEN(32), .IMEM_DEPTH(IMEM), .DMEM_DEPTH(DMEM)) dut (
    .clk       (clk),
    .rst       (rst),
    .prog_we   (prog_we),
    .prog_addr (prog_addr),
    .prog_data (prog_data),
    .run       (run),
    .busy      (busy),
    .halted    (halted),
    .illegal   (illegal),
    .pc_o      (pc_o),
    .dbg_raddr (dbg_raddr),
    .dbg_rdata (dbg_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] enc_r(input int f7, input int f3, input int rd, input int rs1, input int rs2);
    return {7'(f7), 5'(rs2), 5'(rs1), 3'(f3), 5'(rd), 7'h33};
  endfunction

  function automatic logic [31:0] enc_i(input int imm, input int rs1, input int f3, input int rd, input int op);
    return {12'(imm), 5'(rs1), 3'(f3), 5'(rd), 7'(op)};
  endfunction

  function automatic logic [31:0] enc_s(input int imm, input int rs2, input int rs1);
    logic [11:0] im;
    im = 12'(imm);
    return {im[11:5], 5'(rs2), 5'(rs1), 3'b010, im[4:0], 7'h23};
  endfunction

  function automatic logic [31:0] enc_b(input int imm, input int rs2, input int rs1, input int f3);
    logic [12:0] im;
    im = 13'(imm);
    return {im[12], im[10:5], 5'(rs2), 5'(rs1), 3'(f3), im[4:1], im[11], 7'h63};
  endfunction

  function automatic logic [31:0] addi(input int rd, input int rs1, input int imm);
    return enc_i(imm, rs1, 0, rd, 7'h13);
  endfunction

  function automatic logic [31:0] alu_ref(input logic [2:0] f3, input bit alt, input logic [31:0] a, input logic [31:0] b);
    case (f3)
      3'd0: return alt ? a - b : a + b;
      3'd1: return a << b[4:0];
      3'd2: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd3: return (a < b) ? 32'd1 : 32'd0;
      3'd4: return a ^ b;
      3'd5: return alt ? $unsigned($signed(a) >>> b[4:0]) : a >> b[4:0];
      3'd6: return a | b;
      default: return a & b;
    endcase
  endfunction

  task automatic m_set(input logic [4:0] rd, input logic [31:0] v);
    if (rd != 0) m_x[rd] = v;
  endtask

  // Executes whole instructions; each class carries its architectural cycle cost.
  task automatic model_run(output int cyc);
    logic [31:0] w, a, b, ii, si, bi;
    logic [2:0]  f3;
    logic [6:0]  op, f7;
    bit done;
    int steps;
    m_pc = 0; m_ill = 0; cyc = 0; done = 0; steps = 0;
    while (!done && steps < 5000) begin
      steps++;
      w  = m_imem[(m_pc / 4) % IMEM];
      op = w[6:0]; f3 = w[14:12]; f7 = w[31:25];
      a  = m_x[w[19:15]]; b = m_x[w[24:20]];
      ii = {{20{w[31]}}, w[31:20]};
      si = {{20{w[31]}}, w[31:25], w[11:7]};
      bi = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
      if (w == 32'h73) begin
        cyc += 2; done = 1;
      end else if (op == 7'h33 && (f7 == 0 || (f7 == 7'h20 && (f3 == 0 || f3 == 5)))) begin
        m_set(w[11:7], alu_ref(f3, f7 == 7'h20, a, b)); cyc += 4; m_pc += 4;
      end else if (op == 7'h13 && (f3 == 0 || f3 == 2 || f3 == 4 || f3 == 6 || f3 == 7)) begin
        m_set(w[11:7], alu_ref(f3, 1'b0, a, ii)); cyc += 4; m_pc += 4;
      end else if (op == 7'h03 && f3 == 2) begin
        m_set(w[11:7], m_dmem[((a + ii) / 4) % DMEM]); cyc += 5; m_pc += 4;
      end else if (op == 7'h23 && f3 == 2) begin
        m_dmem[((a + si) / 4) % DMEM] = b; cyc += 4; m_pc += 4;
      end else if (op == 7'h63 && (f3 == 0 || f3 == 1)) begin
        if ((f3 == 0) ? (a == b) : (a != b)) m_pc += bi;
        else m_pc += 4;
        cyc += 3;
      end else begin
        m_ill = 1; cyc += 2; done = 1;
      end
    end
  endtask

  task automatic load_prog(input logic [31:0] words[$]);
    foreach (words[i]) begin
      @(negedge clk);
      prog_we = 1'b1; prog_addr = 6'(i); prog_data = words[i];
      m_imem[i] = words[i];
    end
    @(negedge clk);
    prog_we = 1'b0;
  endtask

  task automatic peek(input int i, output logic [31:0] v);
    dbg_raddr = 5'(i);
    #1;
    v = dbg_rdata;
  endtask

  task automatic run_prog(input bit inject, output int cyc);
    @(negedge clk) run = 1'b1;
    @(negedge clk) run = 1'b0;
    cyc = 0;
    if (inject) begin
      check("inject_busy", busy, 1'b1);
      prog_we = 1'b1; prog_addr = 6'd0; prog_data = addi(9, 0, 99);
    end
    while (!halted && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (cyc == 3) prog_we = 1'b0;
    end
    prog_we = 1'b0;
    check("halt_in_budget", 32'(cyc < 3000), 32'd1);
  endtask

  task automatic compare_all(input string tag, input int cyc, input int mcyc);
    logic [31:0] v;
    check({tag, "_cycles"}, 32'(cyc), 32'(mcyc));
    check({tag, "_pc"}, pc_o, m_pc);
    check({tag, "_illegal"}, 32'(illegal), 32'(m_ill));
    check({tag, "_halted"}, 32'(halted), 32'd1);
    for (int i = 0; i < 16; i++) begin
      peek(i, v);
      check($sformatf("%s_x%0d", tag, i), v, m_x[i]);
    end
  endtask

  task automatic do_prog(input string tag, input logic [31:0] words[$], output int cyc);
    int mcyc;
    load_prog(words);
    model_run(mcyc);
    run_prog(1'b0, cyc);
    compare_all(tag, cyc, mcyc);
  endtask

  initial begin
    logic [31:0] prog[$];
    logic [31:0] v;
    int cyc, mcyc, len, kind, f3;

    for (int i = 0; i < 32; i++) m_x[i] = '0;
    for (int i = 0; i < DMEM; i++) m_dmem[i] = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_illegal", 32'(illegal), 32'd0);
    check("rst_pc", pc_o, 32'd0);
    rst = 1'b1;

    prog = {};
    for (int i = 1; i < 16; i++) prog.push_back(addi(i, 0, 100 + 7 * i));
    prog.push_back(32'h73);
    do_prog("reginit", prog, cyc);

    prog = {addi(3, 0, 256), addi(1, 0, 0), enc_s(0, 0, 1), addi(1, 1, 4),
            enc_b(-8, 3, 1, 1), 32'h73};
    do_prog("dmemclr", prog, cyc);
    check("dmemclr_cyc_const", 32'(cyc), 32'd714);

    prog = {addi(1, 0, 5), addi(2, 0, 10), enc_r(0, 0, 3, 1, 2), enc_r(32, 0, 4, 2, 1),
            enc_r(0, 6, 5, 1, 2), enc_r(0, 7, 6, 1, 2), 32'h73};
    do_prog("prog", prog, cyc);
    check("prog_cycles_26", 32'(cyc), 32'd26);
    check("prog_pc_24", pc_o, 32'd24);
    check("prog_illegal", 32'(illegal), 32'd0);
    peek(3, v); check("prog_x3_15", v, 32'd15);
    peek(4, v); check("prog_x4_5", v, 32'd5);
    peek(6, v); check("prog_x6_0", v, 32'd0);

    prog = {addi(1, 0, -7), enc_s(8, 1, 0), enc_i(8, 0, 2, 2, 7'h03), 32'h73};
    do_prog("mem", prog, cyc);
    check("mem_cycles_15", 32'(cyc), 32'd15);
    peek(2, v); check("mem_x2", v, 32'hFFFF_FFF9);

    prog = {addi(1, 0, 3), addi(1, 1, -1), enc_b(-4, 0, 1, 1), 32'h73};
    do_prog("branch", prog, cyc);
    check("branch_cycles_27", 32'(cyc), 32'd27);
    peek(1, v); check("branch_x1", v, 32'd0);

    prog = {32'hFFFF_FFFF};
    do_prog("illegal", prog, cyc);
    check("illegal_cycles_2", 32'(cyc), 32'd2);
    check("illegal_set", 32'(illegal), 32'd1);
    @(negedge clk) run = 1'b1;
    @(negedge clk) run = 1'b0;
    check("illegal_cleared", 32'(illegal), 32'd0);
    repeat (2) @(negedge clk);
    check("illegal_again", 32'(illegal), 32'd1);

    prog = {addi(0, 0, 9), 32'h73};
    do_prog("x0", prog, cyc);
    peek(0, v); check("x0_reads_zero", v, 32'd0);

    prog = {addi(5, 0, 123), enc_s(4 * DMEM, 5, 0), enc_i(0, 0, 2, 6, 7'h03), 32'h73};
    do_prog("swwrap", prog, cyc);
    peek(6, v); check("swwrap_word0", v, 32'd123);

    prog = {addi(9, 0, 21), 32'h73};
    load_prog(prog);
    model_run(mcyc);
    run_prog(1'b1, cyc);
    compare_all("busywe1", cyc, mcyc);
    model_run(mcyc);
    run_prog(1'b0, cyc);
    compare_all("busywe2", cyc, mcyc);
    peek(9, v); check("busywe_x9", v, 32'd21);

    prog = {addi(1, 0, 5), enc_r(0, 0, 12, 1, 1), 32'h73};
    load_prog(prog);
    @(negedge clk) run = 1'b1;
    @(negedge clk) run = 1'b0;
    repeat (6) @(negedge clk);
    check("rstmid_busy_before", 32'(busy), 32'd1);
    check("rstmid_pc_before", pc_o, 32'd4);
    rst = 1'b0;
    #1;
    check("rstmid_busy", 32'(busy), 32'd0);
    check("rstmid_halted", 32'(halted), 32'd0);
    check("rstmid_illegal", 32'(illegal), 32'd0);
    check("rstmid_pc", pc_o, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    m_x[1] = 32'd5;
    peek(1, v); check("rstmid_x1", v, m_x[1]);
    peek(12, v); check("rstmid_x12_kept", v, m_x[12]);

    for (int t = 0; t < 20; t++) begin
      prog = {};
      len = $urandom_range(8, 14);
      for (int i = 0; i < len; i++) begin
        kind = $urandom_range(0, 9);
        if (kind <= 2 || kind == 8) begin
          f3 = $urandom_range(0, 7);
          prog.push_back(enc_r(((f3 == 0 || f3 == 5) && $urandom_range(0, 1) == 1) ? 32 : 0, f3,
                               $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7)));
        end else if (kind <= 4 || kind == 9) begin
          case ($urandom_range(0, 4))
            0: f3 = 0;
            1: f3 = 2;
            2: f3 = 4;
            3: f3 = 6;
            default: f3 = 7;
          endcase
          prog.push_back(enc_i($urandom_range(0, 4095), $urandom_range(0, 7), f3,
                               $urandom_range(0, 7), 7'h13));
        end else if (kind == 5) begin
          prog.push_back(enc_i($urandom_range(0, 4095), $urandom_range(0, 7), 2,
                               $urandom_range(0, 7), 7'h03));
        end else if (kind == 6) begin
          prog.push_back(enc_s($urandom_range(0, 4095), $urandom_range(0, 7), $urandom_range(0, 7)));
        end else begin
          prog.push_back(enc_b(4 * $urandom_range(1, 3), $urandom_range(0, 7),
                               $urandom_range(0, 7), $urandom_range(0, 1)));
        end
      end
      repeat (4) prog.push_back(32'h73);
      do_prog($sformatf("rand%0d", t), prog, cyc);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
